nco_sweep_ctrl: RTL and testbench
=================================

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 SHALL have parameter ACC_FRAC_WIDTH, default 24, fractional bits of NCO step.
REQ-002 SHALL have parameter ACC_INT_WIDTH, default 8, integer bits of NCO step; STEP_W = ACC_FRAC_WIDTH+ACC_INT_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 8, number of sweep-table entries (power of two, >=2).
REQ-004 SHALL have parameter DWELL_W, default 16, width of the per-entry dwell count.
REQ-005 SHALL have ports, clock and reset first: aclk in 1 clock; arst in 1 reset, asynchronous, active-high.
REQ-006 SHALL have ports: cfg_wr_en in 1 table write strobe; cfg_wr_addr in log2(DEPTH) entry index; cfg_wr_step in STEP_W step value; cfg_wr_dwell in DWELL_W dwell cycles; cfg_wr_dither in 1 per-entry dither flag.
REQ-007 SHALL have ports: cfg_last in log2(DEPTH) index of final entry; start in 1 pulse begins sweep; stop in 1 pulse aborts sweep.
REQ-008 SHALL have ports: m_axis_data_tdata out STEP_W step to NCO; m_axis_data_tvalid out 1; m_axis_data_tready in 1.
REQ-009 SHALL have ports: dither_enable out 1; busy out 1; done out 1 one-cycle pulse at sweep end; cur_index out log2(DEPTH) active entry.

Function
REQ-010 SHALL implement states IDLE, LOAD, DWELL, DONE.
REQ-011 IDLE: start -> LOAD with index 0; cfg writes accepted only in IDLE, ignored otherwise.
REQ-012 LOAD: tdata = table[index].step and tvalid = 1, held stable until tready; on tvalid&tready -> DWELL, dwell counter loaded with table[index].dwell.
REQ-013 dither_enable SHALL update to table[index].dither in the same cycle as the LOAD handshake and hold until the next handshake or IDLE.
REQ-014 DWELL: counter decrements each cycle; at count 0 -> LOAD with index+1 if index != cfg_last, else -> DONE; a dwell value of 0 SHALL behave as 1 cycle.
REQ-015 DONE: done = 1 for exactly one cycle, then -> IDLE.
REQ-016 stop in LOAD or DWELL -> IDLE next cycle, tvalid deasserted, no done pulse; stop takes priority over a simultaneous handshake or dwell expiry.
REQ-017 start while not IDLE SHALL be ignored; start and stop in the same IDLE cycle SHALL leave the block in IDLE.
REQ-018 busy = 1 in LOAD and DWELL, 0 otherwise; cur_index reflects the entry being loaded or dwelt.
REQ-019 Index increment SHALL wrap modulo DEPTH; cfg_last is sampled at start and held for the sweep.
REQ-020 Exactly one tvalid&tready handshake SHALL occur per visited entry.

Reset
REQ-021 On arst: state IDLE, index 0, dwell counter 0, tdata 0, tvalid 0, dither_enable 0, busy 0, done 0, cur_index 0.
REQ-022 Reset mid-sweep SHALL abort immediately with no done pulse; table contents SHALL reset to step 0, dwell 0, dither 0.

Configuration
REQ-023 Macro NCO_SWEEP_LOOP_EN: defined -> input port loop_en (1 bit) present; at cfg_last dwell expiry with loop_en = 1, SHALL go to LOAD with index 0, pulse done for one cycle, and stay busy.
REQ-024 Without NCO_SWEEP_LOOP_EN: loop_en port absent; sweep always ends in DONE then IDLE.

Structure
REQ-025 Package nco_sweep_pkg SHALL hold the state enum type and the sweep-entry struct (step, dwell, dither) type.
REQ-026 The table SHALL be a sub-module nco_sweep_table (DEPTH-entry register file, synchronous write, combinational read).

Verification
REQ-027 Table {0x0100_0000/dwell 3/dither 0, 0x0200_0000/dwell 5/dither 1}, cfg_last=1, tready=1, start -> tdata 0x0100_0000 handshake, 4 cycles later 0x0200_0000 with dither 1, done pulse 6 cycles later.
REQ-028 Same table, tready held low 10 cycles in LOAD -> tdata/tvalid stable for 10 cycles, dwell count not started until handshake.
REQ-029 stop in DWELL of entry 0 -> IDLE next cycle, tvalid 0, busy 0, no done pulse.
REQ-030 arst asserted mid-DWELL -> all outputs 0 immediately; new start reads reset table entry (step 0).
REQ-031 cfg_last=7, all dwell 0 -> 8 handshakes on consecutive LOAD/DWELL pairs, index wraps 7 -> done, no index 0 revisit.
REQ-032 With NCO_SWEEP_LOOP_EN, loop_en=1, cfg_last=1 -> entry 0 reloaded after entry 1, done pulse per pass, busy stays 1.

Source files
------------

// File: rtl/nco_sweep_pkg.sv
// Shared types for the NCO sweep controller: FSM state encoding and the sweep-table entry.
// Entry fields are sized to the widest supported step/dwell; narrower builds leave the upper bits at zero.
package nco_sweep_pkg;

    localparam int MAX_STEP_W  = 64;
    localparam int MAX_DWELL_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

    typedef struct packed {
        logic [MAX_STEP_W-1:0]  step;
        logic [MAX_DWELL_W-1:0] dwell;
        logic                   dither;
    } sweep_entry_t;

    function automatic sweep_entry_t make_entry(
        input logic [MAX_STEP_W-1:0]  step,
        input logic [MAX_DWELL_W-1:0] dwell,
        input logic                   dither
    );
        sweep_entry_t e;
        e.step   = step;
        e.dwell  = dwell;
        e.dither = dither;
        return e;
    endfunction

endpackage

// File: rtl/nco_sweep_table.sv
// DEPTH-entry sweep table: synchronous write, combinational read, contents cleared by reset.
module nco_sweep_table
    import nco_sweep_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  sweep_entry_t             wr_entry,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output sweep_entry_t             rd_entry
);

    localparam int AW = $clog2(DEPTH);

    sweep_entry_t mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem[gi] <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    mem[gi] <= wr_entry;
                end
            end
        end
    endgenerate

    assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Steps an NCO through a programmed table of (step, dwell, dither) entries over an AXI-Stream output.
// Optional macro NCO_SWEEP_LOOP_EN adds a loop_en input that restarts the sweep from entry 0 instead of ending.
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int ACC_FRAC_WIDTH = 24,
    parameter int ACC_INT_WIDTH  = 8,
    parameter int DEPTH          = 8,
    parameter int DWELL_W        = 16,
    localparam int STEP_W        = ACC_FRAC_WIDTH + ACC_INT_WIDTH,
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              cfg_wr_en,
    input  logic [AW-1:0]     cfg_wr_addr,
    input  logic [STEP_W-1:0] cfg_wr_step,
    input  logic [DWELL_W-1:0] cfg_wr_dwell,
    input  logic              cfg_wr_dither,
    input  logic [AW-1:0]     cfg_last,
    input  logic              start,
    input  logic              stop,
`ifdef NCO_SWEEP_LOOP_EN
    input  logic              loop_en,
`endif
    output logic [STEP_W-1:0] m_axis_data_tdata,
    output logic              m_axis_data_tvalid,
    input  logic              m_axis_data_tready,
    output logic              dither_enable,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     cur_index
);

    sweep_state_t       state_reg, state_next;
    logic [AW-1:0]      index_reg, index_next;
    logic [AW-1:0]      last_reg, last_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic               dither_reg, dither_next;
    logic               done_reg, done_next;

    sweep_entry_t rd_entry;
    sweep_entry_t wr_entry;
    logic         table_wr_en;
    logic         handshake;
    logic         unused_hi;

    assign table_wr_en = cfg_wr_en && (state_reg == ST_IDLE);
    assign wr_entry    = make_entry(MAX_STEP_W'(cfg_wr_step), MAX_DWELL_W'(cfg_wr_dwell), cfg_wr_dither);

    nco_sweep_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk      (aclk),
        .rst      (arst),
        .wr_en    (table_wr_en),
        .wr_addr  (cfg_wr_addr),
        .wr_entry (wr_entry),
        .rd_addr  (index_reg),
        .rd_entry (rd_entry)
    );

    // Entry bits above the configured widths are always zero.
    assign unused_hi = ^(rd_entry.step >> STEP_W) ^ ^(rd_entry.dwell >> DWELL_W);

    // stop wins over a handshake in the same cycle, so it also suppresses the dither update.
    assign handshake = (state_reg == ST_LOAD) && m_axis_data_tready && !stop;

    always_comb begin
        state_next  = state_reg;
        index_next  = index_reg;
        last_next   = last_reg;
        cnt_next    = cnt_reg;
        dither_next = dither_reg;
        done_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next = ST_LOAD;
                    index_next = '0;
                    last_next  = cfg_last;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (m_axis_data_tready) begin
                    state_next  = ST_DWELL;
                    cnt_next    = rd_entry.dwell[DWELL_W-1:0];
                    dither_next = rd_entry.dither;
                end
            end
            ST_DWELL: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg <= DWELL_W'(1)) begin
                    // A loaded dwell of 0 or 1 both expire after a single DWELL cycle.
                    if (index_reg != last_reg) begin
                        state_next = ST_LOAD;
                        index_next = index_reg + AW'(1);
                    end else begin
`ifdef NCO_SWEEP_LOOP_EN
                        if (loop_en) begin
                            state_next = ST_LOAD;
                            index_next = '0;
                            done_next  = 1'b1;
                        end else
`endif
                        begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg - DWELL_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (state_next == ST_IDLE) begin
            dither_next = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_reg  <= ST_IDLE;
            index_reg  <= '0;
            last_reg   <= '0;
            cnt_reg    <= '0;
            dither_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            index_reg  <= index_next;
            last_reg   <= last_next;
            cnt_reg    <= cnt_next;
            dither_reg <= dither_next;
            done_reg   <= done_next;
        end
    end

    assign m_axis_data_tvalid = (state_reg == ST_LOAD);
    assign m_axis_data_tdata  = m_axis_data_tvalid ? rd_entry.step[STEP_W-1:0] : '0;
    assign busy               = (state_reg == ST_LOAD) || (state_reg == ST_DWELL);
    assign done               = done_reg;
    assign cur_index          = index_reg;
    assign dither_enable      = handshake ? rd_entry.dither : dither_reg;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed + randomized bench for nco_sweep_ctrl; expected traces come from an interval-based sweep model.
module tb_nco_sweep_ctrl;

    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int STEP_W  = 32;
    localparam int DWELL_W = 16;
    localparam int MAXC    = 600;

    logic               aclk = 1'b0;
    logic               arst;
    logic               cfg_wr_en;
    logic [AW-1:0]      cfg_wr_addr;
    logic [STEP_W-1:0]  cfg_wr_step;
    logic [DWELL_W-1:0] cfg_wr_dwell;
    logic               cfg_wr_dither;
    logic [AW-1:0]      cfg_last;
    logic               start;
    logic               stop;
    logic [STEP_W-1:0]  tdata;
    logic               tvalid;
    logic               tready;
    logic               dither_enable;
    logic               busy;
    logic               done;
    logic [AW-1:0]      cur_index;

    nco_sweep_ctrl #(
        .ACC_FRAC_WIDTH (24),
        .ACC_INT_WIDTH  (8),
        .DEPTH          (DEPTH),
        .DWELL_W        (DWELL_W)
    ) dut (
        .aclk               (aclk),
        .arst               (arst),
        .cfg_wr_en          (cfg_wr_en),
        .cfg_wr_addr        (cfg_wr_addr),
        .cfg_wr_step        (cfg_wr_step),
        .cfg_wr_dwell       (cfg_wr_dwell),
        .cfg_wr_dither      (cfg_wr_dither),
        .cfg_last           (cfg_last),
        .start              (start),
        .stop               (stop),
`ifdef NCO_SWEEP_LOOP_EN
        .loop_en            (1'b0),
`endif
        .m_axis_data_tdata  (tdata),
        .m_axis_data_tvalid (tvalid),
        .m_axis_data_tready (tready),
        .dither_enable      (dither_enable),
        .busy               (busy),
        .done               (done),
        .cur_index          (cur_index)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    // Reference table contents as the bench believes they were written.
    logic [STEP_W-1:0] m_step [DEPTH];
    int                m_dwell [DEPTH];
    bit                m_dith [DEPTH];

    // tready per cycle of a sweep, and the expected per-cycle output trace.
    bit                tr [MAXC];
    bit                e_tvalid [MAXC];
    logic [STEP_W-1:0] e_tdata [MAXC];
    bit                e_busy [MAXC];
    bit                e_done [MAXC];
    int                e_idx [MAXC];
    bit                e_dith [MAXC];
    int                n_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            m_step[i]  = '0;
            m_dwell[i] = 0;
            m_dith[i]  = 1'b0;
        end
    endtask

    task automatic write_entry(input int a, input logic [STEP_W-1:0] s, input int d, input bit di);
        cfg_wr_en     = 1'b1;
        cfg_wr_addr   = AW'(a);
        cfg_wr_step   = s;
        cfg_wr_dwell  = DWELL_W'(d);
        cfg_wr_dither = di;
        tick();
        cfg_wr_en     = 1'b0;
        m_step[a]  = s;
        m_dwell[a] = d;
        m_dith[a]  = di;
    endtask

    task automatic set_exp(input int c, input bit v, input logic [STEP_W-1:0] d, input bit b,
                           input bit dn, input int idx, input bit di);
        e_tvalid[c] = v;
        e_tdata[c]  = d;
        e_busy[c]   = b;
        e_done[c]   = dn;
        e_idx[c]    = idx;
        e_dith[c]   = di;
    endtask

    // A sweep is a chain of intervals: each entry waits in LOAD until tready, then dwells
    // max(dwell,1) cycles; after the final entry comes one done cycle and then idle.
    task automatic build_model(input int last);
        int c;
        int idx;
        int d;
        bit dith;
        bit fin;
        bit hs;
        c    = 0;
        idx  = 0;
        dith = 1'b0;
        fin  = 1'b0;
        while (!fin && c < MAXC - 2) begin
            hs = 1'b0;
            while (!hs && c < MAXC - 2) begin
                set_exp(c, 1'b1, m_step[idx], 1'b1, 1'b0, idx, tr[c] ? m_dith[idx] : dith);
                if (tr[c]) begin
                    dith = m_dith[idx];
                    hs   = 1'b1;
                end
                c++;
            end
            d = (m_dwell[idx] == 0) ? 1 : m_dwell[idx];
            for (int k = 0; k < d && c < MAXC - 2; k++) begin
                set_exp(c, 1'b0, '0, 1'b1, 1'b0, idx, dith);
                c++;
            end
            if (idx == last) begin
                set_exp(c, 1'b0, '0, 1'b0, 1'b1, idx, dith);
                c++;
                fin = 1'b1;
            end else begin
                idx = (idx + 1) % DEPTH;
            end
        end
        set_exp(c, 1'b0, '0, 1'b0, 1'b0, idx, 1'b0);
        n_exp = c + 1;
    endtask

    task automatic do_start(input int last);
        cfg_last = AW'(last);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_sweep(input string name, input int last, input bit noise);
        int hs_cnt;
        hs_cnt = 0;
        build_model(last);
        do_start(last);
        for (int c = 0; c < n_exp; c++) begin
            tready = tr[c];
            if (noise && c < n_exp - 2) begin
                // Writes, starts and cfg_last changes mid-sweep must all be ignored.
                start         = ($urandom_range(7) == 0);
                cfg_wr_en     = 1'($urandom_range(1));
                cfg_wr_addr   = AW'($urandom_range(DEPTH - 1));
                cfg_wr_step   = $urandom;
                cfg_wr_dwell  = DWELL_W'($urandom);
                cfg_wr_dither = 1'($urandom_range(1));
                cfg_last      = AW'($urandom_range(DEPTH - 1));
            end else begin
                start     = 1'b0;
                cfg_wr_en = 1'b0;
            end
            @(negedge aclk);
            chk($sformatf("%s tvalid@%0d", name, c), 64'(tvalid), 64'(e_tvalid[c]));
            chk($sformatf("%s tdata@%0d", name, c), 64'(tdata), 64'(e_tdata[c]));
            chk($sformatf("%s busy@%0d", name, c), 64'(busy), 64'(e_busy[c]));
            chk($sformatf("%s done@%0d", name, c), 64'(done), 64'(e_done[c]));
            chk($sformatf("%s cur_index@%0d", name, c), 64'(cur_index), 64'(e_idx[c]));
            chk($sformatf("%s dither@%0d", name, c), 64'(dither_enable), 64'(e_dith[c]));
            if (tvalid && tready) hs_cnt++;
            tick();
        end
        start     = 1'b0;
        cfg_wr_en = 1'b0;
        chk($sformatf("%s handshakes", name), 64'(hs_cnt), 64'(last + 1));
        $display("sweep %s last=%0d cycles=%0d handshakes=%0d", name, last, n_exp, hs_cnt);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, " tvalid"}, 64'(tvalid), 64'd0);
        chk({name, " tdata"}, 64'(tdata), 64'd0);
        chk({name, " busy"}, 64'(busy), 64'd0);
        chk({name, " done"}, 64'(done), 64'd0);
        chk({name, " dither"}, 64'(dither_enable), 64'd0);
    endtask

    initial begin
        arst          = 1'b1;
        cfg_wr_en     = 1'b0;
        cfg_wr_addr   = '0;
        cfg_wr_step   = '0;
        cfg_wr_dwell  = '0;
        cfg_wr_dither = 1'b0;
        cfg_last      = '0;
        start         = 1'b0;
        stop          = 1'b0;
        tready        = 1'b0;
        clear_model();

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        @(negedge aclk);
        check_idle_outputs("reset");
        chk("reset cur_index", 64'(cur_index), 64'd0);
        tick();
        arst = 1'b0;
        tick();

        // Two-entry sweep with tready always high
        write_entry(0, 32'h0100_0000, 3, 1'b0);
        write_entry(1, 32'h0200_0000, 5, 1'b1);
        for (int i = 0; i < MAXC; i++) tr[i] = 1'b1;
        run_sweep("basic", 1, 1'b0);
        chk("basic handshake2 cycle", 64'(e_tdata[4]), 64'h0200_0000);
        chk("basic done cycle", 64'(e_done[10]), 64'd1);

        // tready held low for 10 LOAD cycles
        for (int i = 0; i < MAXC; i++) tr[i] = (i >= 10);
        run_sweep("backpressure", 1, 1'b0);

        // stop during the dwell of entry 0
        for (int i = 0; i < MAXC; i++) tr[i] = 1'b1;
        tready = 1'b1;
        do_start(1);
        @(negedge aclk);
        chk("stop load tvalid", 64'(tvalid), 64'd1);
        tick();
        stop = 1'b1;
        @(negedge aclk);
        chk("stop dwell busy", 64'(busy), 64'd1);
        tick();
        stop = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge aclk);
            check_idle_outputs($sformatf("after stop@%0d", c));
            tick();
        end
        $display("stop test done");

        // Asynchronous reset in the middle of a dwell
        do_start(1);
        tick();
        #1;
        arst = 1'b1;
        #1;
        check_idle_outputs("async reset");
        chk("async reset cur_index", 64'(cur_index), 64'd0);
        clear_model();
        tick();
        arst = 1'b0;
        tick();
        run_sweep("post-reset", 1, 1'b0);

        // All dwell 0, full table, index runs 0..7 once
        for (int a = 0; a < DEPTH; a++) write_entry(a, $urandom, 0, 1'($urandom_range(1)));
        for (int i = 0; i < MAXC; i++) tr[i] = 1'b1;
        run_sweep("full", 7, 1'b0);

        // Randomized tables, lengths and backpressure, with ignored writes/starts
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < DEPTH; a++)
                write_entry(a, $urandom, $urandom_range(4), 1'($urandom_range(1)));
            for (int i = 0; i < MAXC; i++) tr[i] = ($urandom_range(9) < 7);
            run_sweep($sformatf("rand%0d", r), $urandom_range(DEPTH - 1), 1'b1);
        end

        // start and stop together in IDLE leave the block idle
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            check_idle_outputs($sformatf("start+stop@%0d", c));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
